// File: rtl/pll_clken_supervisor.sv
// PLL lock qualifier + downstream reset + NUM_CH fractional clock-enable generators.
// Latency: lock to rst_out release LOCK_HOLD+3 edges; enables registered. Config always ready out of reset. Optional: PLL_CLKEN_ALIGN_EN.
module pll_clken_supervisor #(
  parameter int NUM_CH = 2,
  parameter int ACC_W = 16,
  parameter int LOCK_HOLD = 1024,
  parameter logic [NUM_CH*ACC_W-1:0] INC_INIT = {16'h4000, 16'h8000},
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              pll_locked,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  output logic [NUM_CH-1:0] clken,
  output logic              ready,
  output logic              rst_out,
  output logic              lost_lock
);

  localparam int CNT_W = (LOCK_HOLD > 1) ? $clog2(LOCK_HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_HOLD - 1);

  typedef enum logic [1:0] {WAIT_LOCK, HOLD, RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sync1_q, lock_s;
  logic [ACC_W-1:0]   acc_q [NUM_CH];
  logic [ACC_W-1:0]   inc_q [NUM_CH];
  logic               cfg_wr, cfg_in_range, clear_acc, step;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_s) state_d = HOLD;
      end
      HOLD: begin
        cnt_d = cnt_q + 1'b1;
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RUN;
        end
      end
      RUN: if (!lock_s) state_d = WAIT_LOCK;
      default: state_d = WAIT_LOCK;
    endcase
  end

  always_comb begin
    cfg_wr       = cfg_valid && cfg_ready;
    cfg_in_range = int'(cfg_ch) < NUM_CH;
    step         = (state_q == RUN) && lock_s;
`ifdef PLL_CLKEN_ALIGN_EN
    // In-range writes restart every channel from phase zero together.
    clear_acc    = cfg_wr && cfg_in_range;
`else
    clear_acc    = 1'b0;
`endif
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      lock_s    <= 1'b0;
      state_q   <= WAIT_LOCK;
      cnt_q     <= '0;
      ready     <= 1'b0;
      rst_out   <= 1'b1;
      lost_lock <= 1'b0;
      cfg_ready <= 1'b0;
      clken     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= '0;
        inc_q[i] <= INC_INIT[i*ACC_W +: ACC_W];
      end
    end else begin
      sync1_q   <= pll_locked;
      lock_s    <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ready     <= (state_d == RUN);
      rst_out   <= (state_d != RUN);
      cfg_ready <= 1'b1;
      if (state_q == RUN && !lock_s) lost_lock <= 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        // Carry out of the phase accumulator is the strobe.
        if (step && !clear_acc) begin
          {clken[i], acc_q[i]} <= {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
        end else begin
          clken[i] <= 1'b0;
          acc_q[i] <= '0;
        end
        if (cfg_wr && cfg_in_range && cfg_ch == CH_W'(i)) inc_q[i] <= cfg_inc;
      end
    end
  end

endmodule

// File: tb/tb_pll_clken_supervisor.sv
// Directed bench for pll_clken_supervisor with a lock-run-length / phase-sum reference model.
module tb_pll_clken_supervisor;
  localparam int NCH = 3;
  localparam int AW  = 16;
  localparam int LH  = 8;
  localparam int CHW = 2;
  localparam logic [NCH*AW-1:0] INIT = 48'h2000_4000_8000;

  logic clk = 1'b0, rst = 1'b1, pll_locked = 1'b1, cfg_valid = 1'b0;
  logic [CHW-1:0] cfg_ch = '0;
  logic [AW-1:0]  cfg_inc = '0;
  logic cfg_ready, ready, rst_out, lost_lock;
  logic [NCH-1:0] clken;

  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  pll_clken_supervisor #(.NUM_CH(NCH), .ACC_W(AW), .LOCK_HOLD(LH), .INC_INIT(INIT)) dut (
    .refclk(clk), .rst(rst), .pll_locked(pll_locked), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_inc(cfg_inc), .clken(clken),
    .ready(ready), .rst_out(rst_out), .lost_lock(lost_lock));

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: RUN means lock_s has been seen high on the last LH+1 edges.
  bit m_valid = 1'b0;
  bit m_h1, m_h2, m_ls, m_was_run, m_wr, m_align;
  int m_run_len;
  bit m_ready, m_rst_out, m_lost, m_cfg_rdy;
  bit [NCH-1:0] m_clken;
  int unsigned m_acc [NCH];
  int unsigned m_inc [NCH];

  always @(posedge clk) begin
    if (rst) begin
      m_h1 = 0; m_h2 = 0; m_run_len = 0;
      m_ready = 0; m_rst_out = 1; m_lost = 0; m_cfg_rdy = 0; m_clken = '0;
      for (int c = 0; c < NCH; c++) begin
        m_acc[c] = 0;
        m_inc[c] = int'(INIT >> (c*AW)) & 32'hFFFF;
      end
      m_valid = 1'b1;
    end else begin
      m_ls = m_h2; m_h2 = m_h1; m_h1 = pll_locked;
      m_was_run = m_ready;
      m_run_len = m_ls ? m_run_len + 1 : 0;
      if (m_was_run && !m_ls) m_lost = 1;
      m_wr = cfg_valid && m_cfg_rdy;
      m_align = 0;
`ifdef PLL_CLKEN_ALIGN_EN
      m_align = m_wr && (int'(cfg_ch) < NCH);
`endif
      for (int c = 0; c < NCH; c++) begin
        if (m_was_run && m_ls && !m_align) begin
          m_acc[c] = m_acc[c] + m_inc[c];
          m_clken[c] = (m_acc[c] >= 65536);
          m_acc[c] = m_acc[c] % 65536;
        end else begin
          m_acc[c] = 0;
          m_clken[c] = 0;
        end
      end
      if (m_wr && int'(cfg_ch) < NCH) m_inc[cfg_ch] = cfg_inc;
      m_ready = (m_run_len >= LH + 1);
      m_rst_out = !m_ready;
      m_cfg_rdy = 1;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("m_clken", 32'(clken), 32'(m_clken));
      check("m_ready", 32'(ready), 32'(m_ready));
      check("m_rst_out", 32'(rst_out), 32'(m_rst_out));
      check("m_lost_lock", 32'(lost_lock), 32'(m_lost));
      check("m_cfg_ready", 32'(cfg_ready), 32'(m_cfg_rdy));
    end
  end

  task automatic wait_rst_out(input logic v, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rst_out !== v && n < 200);
  endtask

  task automatic first_strobes(input string tag);
    int f0, f1;
    f0 = -1; f1 = -1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (clken[0] && f0 < 0) f0 = k;
      if (clken[1] && f1 < 0) f1 = k;
    end
    check({tag, "_first_ch0"}, 32'(f0), 32'd2);
    check({tag, "_first_ch1"}, 32'(f1), 32'd4);
  endtask

  task automatic expect_gaps(input int ch, input int g);
    int t;
    t = 0;
    do begin @(negedge clk); t++; end while (!clken[ch] && t < 50);
    for (int k = 0; k < 3; k++) begin
      t = 0;
      do begin @(negedge clk); t++; end while (!clken[ch] && t < 50);
      check($sformatf("gap_ch%0d", ch), 32'(t), 32'(g));
    end
  endtask

  task automatic cfg_write(input logic [CHW-1:0] ch, input logic [AW-1:0] inc);
    cfg_valid = 1'b1; cfg_ch = ch; cfg_inc = inc;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("rst_rst_out", 32'(rst_out), 32'd1);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_clken", 32'(clken), 32'd0);
    check("rst_lost_lock", 32'(lost_lock), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd0);

    rst = 1'b0;
    wait_rst_out(1'b0, n);
    check("bringup_edges", 32'(n), 32'd11);
    check("bringup_ready", 32'(ready), 32'd1);
    first_strobes("run");

    cfg_write(2'd1, 16'h5555);
`ifdef PLL_CLKEN_ALIGN_EN
    check("align_write_clken", 32'(clken), 32'd0);
`endif
    expect_gaps(1, 3);
    expect_gaps(0, 2);
    cfg_write(2'd3, 16'h0001);
    expect_gaps(1, 3);
    expect_gaps(2, 8);

    // Lock loss in RUN, with a config write landing on the loss edge.
    pll_locked = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("loss_edge2_rst_out", 32'(rst_out), 32'd0);
    cfg_write(2'd0, 16'h4000);
    check("loss_rst_out", 32'(rst_out), 32'd1);
    check("loss_clken", 32'(clken), 32'd0);
    check("loss_lost_lock", 32'(lost_lock), 32'd1);
    check("loss_ready", 32'(ready), 32'd0);
    repeat (4) @(negedge clk);
    pll_locked = 1'b1;
    wait_rst_out(1'b0, n);
    check("relock_edges", 32'(n), 32'd11);
    check("relock_lost_lock", 32'(lost_lock), 32'd1);
    expect_gaps(0, 4);
    expect_gaps(1, 3);

    // Mid-operation reset, then a one-cycle lock glitch during HOLD.
    rst = 1'b1;
    @(negedge clk);
    check("rst2_lost_lock", 32'(lost_lock), 32'd0);
    check("rst2_rst_out", 32'(rst_out), 32'd1);
    check("rst2_cfg_ready", 32'(cfg_ready), 32'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    pll_locked = 1'b0;
    @(negedge clk);
    pll_locked = 1'b1;
    wait_rst_out(1'b0, n);
    check("glitch_edges", 32'(n), 32'd11);
    check("glitch_lost_lock", 32'(lost_lock), 32'd0);
    first_strobes("rerun");
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
